// File: rtl/conf_frame_assembler.sv
// Configuration frame assembler.
// Collects parameter bytes (sent highest address first) into shadow registers and copies the
// whole frame to the live configuration bus in one cycle. This only happens when every byte
// arrived in order and no gap between bytes exceeded the timeout. Rejected frames and protocol
// errors increment a saturating error counter. The live bus is never touched by a bad frame.

module conf_frame_assembler #(
  parameter int unsigned NUM_PAR = 6,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned ERR_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      data_ready,
  output logic [NUM_PAR*DATA_W-1:0] conf_bus,
  output logic                      conf_valid,
  output logic                      commit,
  output logic                      busy,
  output logic [ERR_W-1:0]          err_cnt
);

  localparam int unsigned       GapW     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PAR - 1);
  localparam logic [GapW-1:0]   GapMax   = GapW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e                    state_q;
  logic [DATA_W-1:0]         shadow_q [NUM_PAR];
  logic [ADDR_W-1:0]         expected_q;
  logic [GapW-1:0]           gap_q;
  logic                      dr_prev_q;
  logic [NUM_PAR*DATA_W-1:0] conf_bus_q;
  logic                      conf_valid_q;
  logic                      commit_q;
  logic                      busy_q;
  logic [ERR_W-1:0]          err_q;

  logic                      accept;
  logic                      err_evt;
  logic [NUM_PAR*DATA_W-1:0] commit_word;

  // Rising edge of the strobe; dr_prev_q resets high so a strobe held through reset is ignored.
  assign accept = data_ready & ~dr_prev_q;

  // Flag a protocol error: a bad address on accept, or the inter-byte gap running out.
  always_comb begin
    err_evt = 1'b0;
    if (accept) begin
      if (state_q == StIdle) begin
        err_evt = (addr != LastAddr);
      end else begin
        err_evt = (addr != expected_q);
      end
    end else if ((state_q == StCollect) && (gap_q == GapMax)) begin
      err_evt = 1'b1;
    end
  end

  // Full frame as it will appear on the live bus: shadow bytes plus the final byte as param 0.
  always_comb begin
    commit_word                = '0;
    commit_word[DATA_W-1:0]    = data;
    for (int k = 1; k < NUM_PAR; k++) begin
      commit_word[k*DATA_W +: DATA_W] = shadow_q[k];
    end
  end

  // Frame collection FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      expected_q   <= '0;
      gap_q        <= '0;
      dr_prev_q    <= 1'b1;
      conf_bus_q   <= '0;
      conf_valid_q <= 1'b0;
      commit_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
      for (int k = 0; k < NUM_PAR; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      dr_prev_q <= data_ready;
      commit_q  <= 1'b0;

      if (err_evt && (err_q != {ERR_W{1'b1}})) begin
        err_q <= err_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (accept && (addr == LastAddr)) begin
            shadow_q[NUM_PAR-1] <= data;
            expected_q          <= LastAddr - 1'b1;
            gap_q               <= '0;
            state_q             <= StCollect;
            busy_q              <= 1'b1;
          end
        end
        StCollect: begin
          if (accept) begin
            gap_q <= '0;
            if (addr == expected_q) begin
              if (expected_q != '0) begin
                shadow_q[expected_q] <= data;
                expected_q           <= expected_q - 1'b1;
              end else begin
                conf_bus_q   <= commit_word;
                commit_q     <= 1'b1;
                conf_valid_q <= 1'b1;
                state_q      <= StIdle;
                busy_q       <= 1'b0;
              end
            end else if (addr == LastAddr) begin
              // Out-of-order frame start: drop the current frame and begin a new one.
              shadow_q[NUM_PAR-1] <= data;
              expected_q          <= LastAddr - 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else if (gap_q == GapMax) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign conf_bus   = conf_bus_q;
  assign conf_valid = conf_valid_q;
  assign commit     = commit_q;
  assign busy       = busy_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_conf_frame_assembler.sv
// Bench for conf_frame_assembler: directed frames, with expected commits queued at issue time
// and compared by an independent monitor whenever the commit pulse appears.

module tb_conf_frame_assembler;

  localparam int unsigned NumPar  = 6;
  localparam int unsigned DataW   = 8;
  localparam int unsigned AddrW   = 3;
  localparam int unsigned Timeout = 4096;
  localparam int unsigned ErrW    = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [DataW-1:0]         data = '0;
  logic [AddrW-1:0]         addr = '0;
  logic                     data_ready = 1'b0;
  logic [NumPar*DataW-1:0]  conf_bus;
  logic                     conf_valid;
  logic                     commit;
  logic                     busy;
  logic [ErrW-1:0]          err_cnt;

  typedef struct packed {
    logic [47:0] bus;
    logic [7:0]  err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_err  = 0;
  logic [47:0] exp_bus  = '0;

  conf_frame_assembler #(
    .NUM_PAR (NumPar),
    .DATA_W  (DataW),
    .ADDR_W  (AddrW),
    .TIMEOUT (Timeout),
    .ERR_W   (ErrW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .addr       (addr),
    .data_ready (data_ready),
    .conf_bus   (conf_bus),
    .conf_valid (conf_valid),
    .commit     (commit),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_conf_bus"}, 64'(conf_bus), 64'h0);
    check({tag, "_conf_valid"}, 64'(conf_valid), 64'h0);
    check({tag, "_commit"}, 64'(commit), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'h0);
  endtask

  // Called at a negedge: strobe high for 'hold' cycles, then low for 'gap' cycles.
  // The accept happens on the posedge right after the call.
  task automatic send_byte(input int a, input logic [7:0] d, input int hold, input int gap);
    addr       = AddrW'(a);
    data       = d;
    data_ready = 1'b1;
    repeat (hold) @(negedge clk);
    data_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Sends a full in-order frame and queues the expected commit before the last byte goes out.
  task automatic send_frame(input logic [47:0] bus, input int hold, input int gap);
    exp_t e;
    for (int k = NumPar - 1; k >= 0; k--) begin
      if (k == 0) begin
        exp_bus = bus;
        e.bus   = bus;
        e.err   = 8'(exp_err);
        sb_q.push_back(e);
      end
      send_byte(k, bus[k*8 +: 8], hold, gap);
    end
  endtask

  // Monitor: compares every commit against the queue and checks the pulse is one cycle wide.
  initial begin
    bit   commit_seen;
    exp_t e;
    commit_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (commit_seen) check("commit_width", 64'(commit), 64'h0);
      commit_seen = commit;
      if (commit === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_commit: got conf_bus 0x%0h, expected no commit", conf_bus);
        end else begin
          e = sb_q.pop_front();
          check("commit_conf_bus", 64'(conf_bus), 64'(e.bus));
          check("commit_conf_valid", 64'(conf_valid), 64'h1);
          check("commit_err_cnt", 64'(err_cnt), 64'(e.err));
        end
      end
    end
  end

  initial begin
    // Reset with the strobe (and a valid start address) already high.
    rst = 1'b1; data_ready = 1'b1; addr = 3'd5; data = 8'h99;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("held_strobe_busy", 64'(busy), 64'h0);
    check("held_strobe_err", 64'(err_cnt), 64'h0);
    data_ready = 1'b0;
    @(negedge clk);

    // Frame A, bytes 600 cycles apart.
    send_frame(48'h112233445566, 1, 599);
    check("frameA_busy", 64'(busy), 64'h0);
    check("frameA_valid", 64'(conf_valid), 64'h1);
    check("frameA_err", 64'(err_cnt), 64'h0);

    // Frame B breaks off at addr 2 instead of 3.
    send_byte(5, 8'hA1, 1, 1);
    send_byte(4, 8'hA2, 1, 1);
    send_byte(2, 8'hA3, 1, 1);
    exp_err++;
    check("skip_err", 64'(err_cnt), 64'(exp_err));
    check("skip_busy", 64'(busy), 64'h0);
    check("skip_bus_kept", 64'(conf_bus), 64'(exp_bus));

    // Frame C commits normally.
    send_frame(48'hC5C4C3C2C1C0, 1, 2);

    // Timeout after addr 3: error exactly 4096 cycles after the last accept.
    send_byte(5, 8'hD5, 1, 1);
    send_byte(4, 8'hD4, 1, 1);
    send_byte(3, 8'hD3, 1, 0);
    repeat (Timeout - 1) @(negedge clk);
    check("timeout_pre_err", 64'(err_cnt), 64'(exp_err));
    check("timeout_pre_busy", 64'(busy), 64'h1);
    @(negedge clk);
    exp_err++;
    check("timeout_err", 64'(err_cnt), 64'(exp_err));
    check("timeout_busy", 64'(busy), 64'h0);
    check("timeout_bus_kept", 64'(conf_bus), 64'(exp_bus));

    // Next accept lands on the timeout threshold cycle: the accept wins.
    send_byte(5, 8'h75, 1, 1);
    send_byte(4, 8'h74, 1, 1);
    send_byte(3, 8'h73, 1, Timeout - 1);
    send_byte(2, 8'h72, 1, 1);
    check("edge_accept_err", 64'(err_cnt), 64'(exp_err));
    check("edge_accept_busy", 64'(busy), 64'h1);
    send_byte(1, 8'h71, 1, 1);
    begin
      exp_t e;
      e.bus = 48'h757473727170;
      e.err = 8'(exp_err);
      sb_q.push_back(e);
      exp_bus = e.bus;
    end
    send_byte(0, 8'h70, 1, 2);

    // Mid-frame restart: 5,4,5,4,3,2,1,0 commits the second frame's bytes.
    send_byte(5, 8'hE5, 1, 1);
    send_byte(4, 8'hE4, 1, 1);
    send_byte(5, 8'hF5, 1, 1);
    exp_err++;
    check("restart_err", 64'(err_cnt), 64'(exp_err));
    check("restart_busy", 64'(busy), 64'h1);
    send_byte(4, 8'hF4, 1, 1);
    send_byte(3, 8'hF3, 1, 1);
    send_byte(2, 8'hF2, 1, 1);
    send_byte(1, 8'hF1, 1, 1);
    begin
      exp_t e;
      e.bus = 48'hF5F4F3F2F1F0;
      e.err = 8'(exp_err);
      sb_q.push_back(e);
      exp_bus = e.bus;
    end
    send_byte(0, 8'hF0, 1, 2);

    // Strobe held high 10 cycles per byte: one accept per rising edge.
    send_frame(48'h151413121110, 10, 2);
    check("long_strobe_err", 64'(err_cnt), 64'(exp_err));

    // Back-to-back frames with the minimum strobe spacing.
    send_frame(48'h353433323130, 1, 1);
    send_frame(48'h454443424140, 1, 2);
    check("b2b_err", 64'(err_cnt), 64'(exp_err));
    check("b2b_bus", 64'(conf_bus), 64'(exp_bus));

    // Reset pulse after addr 2 discards everything.
    send_byte(5, 8'h25, 1, 1);
    send_byte(4, 8'h24, 1, 1);
    send_byte(3, 8'h23, 1, 1);
    send_byte(2, 8'h22, 1, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    exp_err = 0;
    exp_bus = '0;
    @(negedge clk);
    send_byte(1, 8'hAA, 1, 1);
    check("post_reset_addr1_err", 64'(err_cnt), 64'h1);
    check("post_reset_busy", 64'(busy), 64'h0);

    // 300 stray bytes in total drive the counter into saturation without wrapping.
    for (int i = 0; i < 254; i++) send_byte(3, 8'h33, 1, 1);
    check("sat_reach", 64'(err_cnt), 64'd255);
    for (int i = 0; i < 46; i++) send_byte(3, 8'h33, 1, 1);
    check("sat_hold", 64'(err_cnt), 64'd255);
    check("sat_bus", 64'(conf_bus), 64'h0);
    check("sat_valid", 64'(conf_valid), 64'h0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conf_frame_assembler.md
# conf_frame_assembler

Downstream consumer of the UART receiver. It takes each received configuration byte together with its parameter address and assembles a complete configuration frame in shadow registers. Only when all parameters of a frame have arrived in order, without gaps exceeding a timeout, does it atomically commit them to the live configuration bus read by the DRSSTC timing logic. Partial or corrupt frames never reach the live bus.

## Interface
- `NUM_PAR`, 6: parameters per frame; address range 0..NUM_PAR-1.
- `DATA_W`, 8: bits per parameter byte.
- `ADDR_W`, 3: address width; must satisfy 2^ADDR_W ≥ NUM_PAR.
- `TIMEOUT`, 4096: maximum clk cycles allowed between accepted bytes inside a frame.
- `ERR_W`, 8: error counter width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  DATA_W  received byte, valid when `data_ready` rises.
- `addr`  in  ADDR_W  parameter address of `data`.
- `data_ready`  in  1  byte-available strobe; a byte is taken on its rising edge only.
- `conf_bus`  out  NUM_PAR*DATA_W  live parameters; parameter k occupies bits [k*DATA_W+DATA_W-1 : k*DATA_W].
- `conf_valid`  out  1  high once at least one frame has committed since reset.
- `commit`  out  1  one-cycle pulse marking the cycle in which `conf_bus` first shows a new frame.
- `busy`  out  1  high while in COLLECT.
- `err_cnt`  out  ERR_W  saturating count of rejected frames and protocol errors.

## Operation
- Accept event: `data_ready`=1 in the current cycle and =0 in the previous cycle. The previous-value register resets to 1, so a strobe already held high out of reset is not accepted.
- Frame order is fixed: addresses NUM_PAR-1, NUM_PAR-2, …, 0. Address 0 is the last byte of a frame.
- Registers:
  - `shadow[NUM_PAR]`
  - `expected` (ADDR_W)
  - `gap_cnt`, wide enough for TIMEOUT
  - `state` ∈ {IDLE, COLLECT}
- IDLE:
  - Accept with `addr`==NUM_PAR-1: write `shadow[NUM_PAR-1]`, set `expected`=NUM_PAR-2, clear `gap_cnt`, go to COLLECT.
  - Accept with any other `addr`, including ≥NUM_PAR: error; stay in IDLE.
- COLLECT:
  - `gap_cnt` increments every cycle without an accept and clears on every accept.
  - Accept with `addr`==`expected` and `expected`≠0: write `shadow[expected]`, decrement `expected`.
  - Accept with `addr`==`expected`==0: load `conf_bus` from `shadow[NUM_PAR-1:1]` plus this byte as parameter 0. Pulse `commit`, set `conf_valid`, go to IDLE.
  - Accept with a wrong `addr` that equals NUM_PAR-1: error; restart the frame with this byte, following the IDLE rule.
  - Accept with a wrong `addr` otherwise: error; go to IDLE.
  - `gap_cnt` reaches TIMEOUT-1 with no accept in that cycle: error; go to IDLE.
- When an accept and the timeout threshold fall in the same cycle, the accept wins and there is no error.
- Error action: `err_cnt` += 1, saturating at 2^ERR_W-1. At most one increment per cycle. `conf_bus` is never modified.
- Shadow contents from an abandoned frame are don't-care; they are always fully overwritten before any commit.

## Timing
- Reset values:
  - `conf_bus`=0, `conf_valid`=0, `commit`=0, `busy`=0, `err_cnt`=0
  - state=IDLE, `expected`=0, `gap_cnt`=0, `shadow`=0
- Reset asserted mid-frame discards the frame and does not clear `rst`-independent state (there is none). After reset, the first accept must be address NUM_PAR-1.
- Latency: accept sampled at clock edge N; `shadow`, `state` and `err_cnt` update at edge N. On the final byte, `conf_bus`, `commit`=1 and `conf_valid`=1 are all visible from edge N to N+1. `commit` drops at edge N+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `busy` mirrors state==COLLECT, registered.
- Back-to-back frames are allowed: an accept at addr NUM_PAR-1 in the cycle right after a commit starts a new frame.
- Timeout: the error fires at the edge where TIMEOUT cycles have elapsed since the last accept with no new accept.

## Test plan
- Reset, then bytes 0x11,0x22,0x33,0x44,0x55,0x66 at addrs 5..0, each strobe 1 cycle high, 600 cycles apart → one cycle after the addr-0 accept, `conf_bus`=0x112233445566 (param5 in the MSB byte), `commit` high for exactly 1 cycle, `conf_valid`=1, `err_cnt`=0.
- Valid frame A committed, then frame B with addr sequence 5,4,2 → `err_cnt`=1, state IDLE, `conf_bus` still equals A. A following full frame C commits C.
- Bytes at addrs 5,4,3 followed by 4096 idle cycles → `err_cnt` increments exactly at cycle 4096 after the last accept, `busy` falls, `conf_bus` is unchanged. A variant with the next accept at exactly cycle TIMEOUT-1 raises no error.
- Mid-frame addr 5 (sequence 5,4,5,4,3,2,1,0) → `err_cnt`=1, and the commit holds the second frame's bytes.
- `data_ready` held high for 10 cycles per byte, and high during reset release → exactly one accept per rising edge, none at reset release. `rst` pulsed after addr 2 → all outputs return to their reset values.
- 300 stray addr-3 bytes in IDLE → `err_cnt` saturates at 255 with no wrap.
